// File: rtl/pll_clken_gen.sv
// N-channel fractional clock-enable generator with PLL lock qualification.
// Optional lol_count output enabled by defining PLL_CLKEN_GEN_LOL_COUNT_EN.
module pll_clken_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEFAULT_INC = 335544,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              lock_in,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              align,
    output logic              locked,
    output logic [NUM_CH-1:0] tick,
`ifdef PLL_CLKEN_GEN_LOL_COUNT_EN
    output logic [7:0]        lol_count,
`endif
    output logic [NUM_CH-1:0] clk_en_sq
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        SETTLING,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;

    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [ACC_W:0]   sum [NUM_CH];
    logic             accumulate;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= UNLOCKED;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        case (state)
            UNLOCKED: begin
                if (lock_in) begin
                    state_nxt      = SETTLING;
                    settle_cnt_nxt = '0;
                end
            end
            SETTLING: begin
                if (!lock_in)
                    state_nxt = UNLOCKED;
                else if (settle_cnt == CNT_LAST)
                    state_nxt = RUN;
                else
                    settle_cnt_nxt = settle_cnt + 1'b1;
            end
            RUN: begin
                if (!lock_in)
                    state_nxt = UNLOCKED;
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    assign locked = (state == RUN);

    // Losing lock or aligning zeroes accumulators and outputs in the same edge.
    assign accumulate = (state == RUN) && lock_in && !align;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++)
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= ACC_W'(DEFAULT_INC);
            end
            tick      <= '0;
            clk_en_sq <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (accumulate) begin
                    acc[i]       <= sum[i][ACC_W-1:0];
                    tick[i]      <= sum[i][ACC_W];
                    clk_en_sq[i] <= sum[i][ACC_W-1];
                end else begin
                    acc[i]       <= '0;
                    tick[i]      <= 1'b0;
                    clk_en_sq[i] <= 1'b0;
                end
                // Out-of-range channel indices match no channel and are dropped.
                if (cfg_we && (cfg_ch == CH_W'(i)))
                    inc[i] <= cfg_inc;
            end
        end
    end

`ifdef PLL_CLKEN_GEN_LOL_COUNT_EN
    always_ff @(posedge refclk) begin
        if (rst)
            lol_count <= '0;
        else if ((state == RUN) && (state_nxt == UNLOCKED) && (lol_count != 8'hFF))
            lol_count <= lol_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pll_clken_gen.sv
// Scoreboard bench for pll_clken_gen: driver pushes model predictions, monitor compares.
module tb_pll_clken_gen;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int DEFAULT_INC = 20;
    localparam int CH_W        = 2;
    localparam int ACC_MOD     = 1 << ACC_W;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              lock_in = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic              align = 1'b0;
    logic              locked;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_en_sq;
`ifdef PLL_CLKEN_GEN_LOL_COUNT_EN
    logic [7:0]        lol_count;
`endif

    pll_clken_gen #(
        .NUM_CH(NUM_CH),
        .ACC_W(ACC_W),
        .LOCK_CYCLES(LOCK_CYCLES),
        .DEFAULT_INC(DEFAULT_INC)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .lock_in(lock_in),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc),
        .align(align),
        .locked(locked),
        .tick(tick),
`ifdef PLL_CLKEN_GEN_LOL_COUNT_EN
        .lol_count(lol_count),
`endif
        .clk_en_sq(clk_en_sq)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic              locked;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sq;
        int                lol;
        bit                cnt_en;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cnt_dut[NUM_CH];

    // Reference model: lock = enough consecutive high samples; phase as plain integers.
    int hc = 0;
    bit m_locked = 1'b0;
    int ph[NUM_CH];
    int incm[NUM_CH];
    int m_lol = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic step(input bit r, input bit l, input bit we = 0, input int ch = 0,
                        input int iv = 0, input bit al = 0, input bit ce = 0);
        exp_t e;
        bit   prev;
        int   total;
        @(negedge refclk);
        rst = r; lock_in = l; cfg_we = we; cfg_ch = CH_W'(ch);
        cfg_inc = ACC_W'(iv); align = al;
        e.tick = '0;
        e.sq = '0;
        prev = m_locked;
        if (r) begin
            hc = 0;
            m_locked = 1'b0;
            m_lol = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                ph[i] = 0;
                incm[i] = DEFAULT_INC;
            end
        end else begin
            hc = l ? ((hc < LOCK_CYCLES + 1) ? hc + 1 : hc) : 0;
            m_locked = (hc >= LOCK_CYCLES + 1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (prev && m_locked && !al) begin
                    total = ph[i] + incm[i];
                    e.tick[i] = (total >= ACC_MOD);
                    ph[i] = total % ACC_MOD;
                end else begin
                    ph[i] = 0;
                end
                e.sq[i] = (ph[i] >= ACC_MOD / 2);
            end
            if (prev && !m_locked && m_lol < 255) m_lol++;
            if (we && ch < NUM_CH) incm[ch] = iv;
        end
        e.locked = m_locked;
        e.lol = m_lol;
        e.cnt_en = ce;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input bit l = 1, input bit ce = 0);
        repeat (n) step(0, l, 0, 0, 0, 0, ce);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(posedge refclk); #2;
            k++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_CH; i++) cnt_dut[i] = 0;
    endtask

    // Monitor: the DUT presents a result every cycle; pop and compare one per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge refclk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("locked", int'(locked), int'(e.locked));
                chk("tick", int'(tick), int'(e.tick));
                chk("clk_en_sq", int'(clk_en_sq), int'(e.sq));
`ifdef PLL_CLKEN_GEN_LOL_COUNT_EN
                chk("lol_count", int'(lol_count), e.lol);
`endif
                if (e.cnt_en)
                    for (int i = 0; i < NUM_CH; i++) cnt_dut[i] += int'(tick[i]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lock qualification, including a glitch during settling
        step(1, 0); step(1, 0);
        run(20);
        step(1, 0);
        run(10); run(1, 0); run(20);

        // Rates: ch0 every 4, ch1 every 2, ch2 frozen
        step(0, 1, 1, 0, 64);
        step(0, 1, 1, 1, 128);
        step(0, 1, 1, 2, 0, 1);
        drain(); clear_counts();
        run(100, 1, 1);
        drain();
        chk("ch2_ticks_inc0", cnt_dut[2], 0);
        chk("ch0_ticks_inc64", cnt_dut[0], 25);
        chk("ch1_ticks_inc128", cnt_dut[1], 50);

        // Fractional rate: inc=96 written together with align
        step(0, 1, 1, 0, 96, 1);
        drain(); clear_counts();
        run(64, 1, 1);
        drain();
        chk("ch0_ticks_inc96", cnt_dut[0], 24);

        // Loss of lock with live accumulators, then re-lock
        run(5);
        run(1, 0);
        run(30);

        // align with simultaneous cfg write, then an out-of-range write
        step(0, 1, 1, 0, 64);
        run(3);
        step(0, 1, 1, 1, 32, 1);
        run(20);
        step(0, 1, 1, NUM_CH, 5);
        run(20);

        // Mid-run reset restores defaults
        step(1, 1);
        run(40);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            bit r, l, we, al;
            int ch, iv;
            r  = ($urandom_range(0, 499) == 0);
            l  = ($urandom_range(0, 149) != 0);
            we = ($urandom_range(0, 15) == 0);
            ch = $urandom_range(0, 3);
            iv = (($urandom_range(0, 3) == 0) ? 128 : 0) + $urandom_range(0, 127);
            al = ($urandom_range(0, 39) == 0);
            step(r, l, we, ch, iv, al);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
